fetch_stage: RTL

Instruction-fetch front end of the five-stage pipeline. It owns the fetch PC and drives a valid/ready request with a one-outstanding response to instruction memory. It also owns the IF/ID pipeline register. It consumes the `pc_write` and `if_id_write` controls produced by the load-use hazard logic and the `flush` redirect produced by EX on taken branches and jumps, and turns them into PC holds, IF/ID holds and bubble insertion.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_hold_buf.sv | 53 +++++
 rtl/fetch_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch stage
package fetch_pkg;
    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry buffer catching a response while IF/ID is held
module fetch_hold_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            buf_valid,
    output logic [XLEN-1:0] buf_pc,
    output logic [XLEN-1:0] buf_instr
);
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;

    // Clear wins over load so a flush can never leave a stale entry behind.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign buf_valid = valid_q;
    assign buf_pc    = pc_q;
    assign buf_instr = instr_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch PC, one-outstanding imem request FSM and IF/ID register
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            fetch_busy
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            live_rsp;
    logic            buf_load, buf_drain;
    logic            buf_valid;
    logic [XLEN-1:0] buf_pc, buf_instr;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        live_rsp   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pc_write && !buf_valid && !flush) begin
                    state_d  = REQ;
                    req_pc_d = fetch_pc_q;
                end
            end
            REQ: begin
                // The request stays up until accepted even if flushed; kill marks it dead.
                if (imem_req_ready) begin
                    state_d = WAIT;
                    if (!flush && !kill_q) begin
                        fetch_pc_d = req_pc_q + XLEN'(4);
                    end
                end
                if (flush) begin
                    kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d  = IDLE;
                    kill_d   = 1'b0;
                    live_rsp = !kill_q && !flush;
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            fetch_pc_d = {flush_target[XLEN-1:2], 2'b00};
        end
        req_valid_d = (state_d == REQ);
    end

    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        buf_load      = 1'b0;
        buf_drain     = 1'b0;
        if (flush) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (live_rsp && if_id_write && !buf_valid) begin
            if_id_pc_d    = req_pc_q;
            if_id_instr_d = imem_rsp_data;
            if_id_valid_d = 1'b1;
        end else if (live_rsp) begin
            buf_load = 1'b1;
        end else if (if_id_write) begin
            if (buf_valid) begin
                if_id_pc_d    = buf_pc;
                if_id_instr_d = buf_instr;
                if_id_valid_d = 1'b1;
                buf_drain     = 1'b1;
            end else begin
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            kill_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            kill_q        <= kill_d;
            req_valid_q   <= req_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    fetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .drain      (buf_drain),
        .clear      (flush),
        .load_pc    (req_pc_q),
        .load_instr (imem_rsp_data),
        .buf_valid  (buf_valid),
        .buf_pc     (buf_pc),
        .buf_instr  (buf_instr)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_pc_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_valid    = if_id_valid_q;
    assign fetch_busy     = (state_q != IDLE);
endmodule
